// File: rtl/dff_chk_pkg.sv
// rtl/dff_chk_pkg.sv - shared types and constants for the flip-flop checker
//
// Purpose : state encoding, default error limit and the compare-value helper
//           used by dff_checker.
// Ports   : none (package).

package dff_chk_pkg;

  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    VALID   = 2'd1,
    HALT    = 2'd2
  } chk_state_e;

  localparam int unsigned ERR_LIMIT_DEFAULT = 8;
  localparam int unsigned ERR_CNT_W         = 8;

  // Clear dominates preset, preset dominates the held/sampled value.
  function automatic logic prio_value(input logic clr, input logic pre, input logic val);
    if (clr) begin
      return 1'b0;
    end else if (pre) begin
      return 1'b1;
    end
    return val;
  endfunction

endpackage

// File: rtl/dff_evt_catch.sv
// rtl/dff_evt_catch.sv - asynchronous-set, clock-cleared event flag
//
// Purpose : remembers a rising edge of evt_in that happened between clock
//           edges; the flag is consumed (cleared) by the next clock edge.
// Ports   : clock  - checker clock, rising edge
//           reset  - asynchronous active-high reset
//           evt_in - asynchronous level whose rising edge is captured
//           flag   - high while an uncollected rising edge is pending

module dff_evt_catch (
  input  logic clock,
  input  logic reset,
  input  logic evt_in,
  output logic flag
);

  // Two toggles: one flips on every evt_in rising edge, the other follows it
  // on the clock. Their XOR is the pending flag, so an edge arriving at any
  // time is never overwritten by the clock-side clear.
  logic set_tgl_q, set_tgl_d;
  logic clr_tgl_q, clr_tgl_d;

  always_comb begin
    set_tgl_d = ~set_tgl_q;
    clr_tgl_d = set_tgl_q;
  end

  always_ff @(posedge evt_in or posedge reset) begin
    if (reset) begin
      set_tgl_q <= 1'b0;
    end else begin
      set_tgl_q <= set_tgl_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clr_tgl_q <= 1'b0;
    end else begin
      clr_tgl_q <= clr_tgl_d;
    end
  end

  assign flag = set_tgl_q ^ clr_tgl_q;

endmodule

// File: rtl/dff_checker.sv
// rtl/dff_checker.sv - reference-model checker for a D flip-flop with async clear/preset
//
// Purpose : models the observed flop, compares its q on every clock edge while
//           VALID and counts comparisons and failures; halts at ERR_LIMIT errors.
// Ports   : clock, reset      - clock (rising) and asynchronous active-high reset
//           enable            - checking enable
//           d, clear, preset  - observed flop inputs (clear/preset asynchronous)
//           q                 - observed flop output
//           expected_q        - modelled flop value
//           mismatch          - one-cycle registered pulse on a failed compare
//           error_count       - saturating failure count (8 bits)
//           check_count       - saturating comparison count (CNT_W bits)
//           halted            - high in HALT
//           state             - current FSM state

module dff_checker
  import dff_chk_pkg::*;
#(
  parameter int unsigned ERR_LIMIT = ERR_LIMIT_DEFAULT,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 d,
  input  logic                 clear,
  input  logic                 preset,
  input  logic                 q,
  output logic                 expected_q,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] error_count,
  output logic [CNT_W-1:0]     check_count,
  output logic                 halted,
  output logic [1:0]           state
);

  localparam logic [ERR_CNT_W-1:0] LAST_ERR = ERR_CNT_W'(ERR_LIMIT - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  chk_state_e           state_q, state_d;
  logic                 exp_val_q, exp_val_d;
  logic                 mismatch_q, mismatch_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]     chk_cnt_q, chk_cnt_d;

  logic clr_evt, pre_evt;
  logic cmp_val, nxt_val, do_cmp, fail, limit_hit;

  // Short clear/preset pulses between clock edges still affect the compare.
  dff_evt_catch u_clr_catch (
    .clock  (clock),
    .reset  (reset),
    .evt_in (clear),
    .flag   (clr_evt)
  );

  dff_evt_catch u_pre_catch (
    .clock  (clock),
    .reset  (reset),
    .evt_in (preset),
    .flag   (pre_evt)
  );

  always_comb begin
    cmp_val   = prio_value(clr_evt | clear, pre_evt | preset, exp_val_q);
    nxt_val   = prio_value(clear, preset, d);
    do_cmp    = (state_q == VALID) && enable;
    fail      = do_cmp && (q != cmp_val);
    limit_hit = fail && (err_cnt_q == LAST_ERR);
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= UNKNOWN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      UNKNOWN: if (enable) state_d = VALID;
      VALID: begin
        if (!enable) begin
          state_d = UNKNOWN;
        end else if (limit_hit) begin
          state_d = HALT;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = UNKNOWN;
    endcase
  end

  // Model value and counters; everything holds in HALT.
  always_comb begin
    exp_val_d  = exp_val_q;
    mismatch_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    chk_cnt_d  = chk_cnt_q;
    if ((state_q == UNKNOWN) && enable) begin
      exp_val_d = nxt_val;
    end
    if (do_cmp) begin
      exp_val_d = nxt_val;
      if (chk_cnt_q != '1) begin
        chk_cnt_d = chk_cnt_q + CNT_ONE;
      end
      if (fail) begin
        mismatch_d = 1'b1;
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_val_q  <= 1'b0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
      chk_cnt_q  <= '0;
    end else begin
      exp_val_q  <= exp_val_d;
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
      chk_cnt_q  <= chk_cnt_d;
    end
  end

  // Outputs
  always_comb begin
    expected_q  = exp_val_q;
    mismatch    = mismatch_q;
    error_count = err_cnt_q;
    check_count = chk_cnt_q;
    halted      = (state_q == HALT);
    state       = state_q;
  end

endmodule

// File: doc/dff_checker.md
DFF_CHECKER -- requirements
Module: dff_checker

Interface
REQ-001 Parameter ERR_LIMIT, default 8: error count at which checking halts; legal range 1..255.
REQ-002 Parameter CNT_W, default 16: width of check_count.
REQ-003 clock  input  1  single clock, rising edge; one clock, reset is asynchronous and active-high.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  checking enable, sampled on clock.
REQ-006 d  input  1  observed DUT data input.
REQ-007 clear  input  1  observed DUT asynchronous clear, active-high.
REQ-008 preset  input  1  observed DUT asynchronous preset, active-high.
REQ-009 q  input  1  observed DUT output under check.
REQ-010 expected_q  output  1  modelled flip-flop value.
REQ-011 mismatch  output  1  one-cycle pulse, registered, on a failed comparison.
REQ-012 error_count  output  8  saturating failed-comparison count.
REQ-013 check_count  output  CNT_W  saturating comparison count.
REQ-014 halted  output  1  high once error_count reaches ERR_LIMIT.
REQ-015 state  output  2  current FSM state encoding.

Function
REQ-016 Clear has priority over preset; preset has priority over d in the model.
REQ-017 Rising edges of clear and preset between clock edges SHALL be captured by event flags (clr_evt, pre_evt), set asynchronously and cleared on the clock edge that consumes them.
REQ-018 FSM states: UNKNOWN, VALID, HALT.
REQ-019 UNKNOWN: no comparison. If enable=1 at an edge, go to VALID and load expected_q.
REQ-020 VALID: compare at each edge, then reload expected_q. If enable=0 at an edge, go to UNKNOWN with no comparison.
REQ-021 HALT: entered on the edge at which error_count becomes ERR_LIMIT. Comparisons and counters freeze. Exit only by reset.
REQ-022 Compare value at an edge is 0 if clr_evt or clear, else 1 if pre_evt or preset, else expected_q.
REQ-023 Next expected_q is 0 if clear, else 1 if preset, else d, all sampled at the same edge.
REQ-024 Each comparison increments check_count by 1, saturating at all-ones.
REQ-025 If q differs from the compare value: mismatch=1 for the next cycle and error_count increments, saturating at 255.
REQ-026 Latency: mismatch asserts exactly one clock after the edge whose comparison failed.
REQ-027 Simultaneous clear and preset: model 0; no error counted for q=0.
REQ-028 When an event flag is set and a clock edge occurs in the same timestep, the event SHALL be consumed at that edge, not lost.

Reset
REQ-029 While reset is asserted, all of the following hold:
- state=UNKNOWN, expected_q=0, mismatch=0
- error_count=0, check_count=0, halted=0
- clr_evt=0, pre_evt=0
REQ-030 Reset mid-operation, including in HALT, SHALL abandon the pending comparison and produce no mismatch pulse.

Structure
REQ-031 Shared package dff_chk_pkg SHALL hold the state enum (UNKNOWN=0, VALID=1, HALT=2) and the ERR_LIMIT default constant.
REQ-032 Sub-module dff_evt_catch SHALL implement one asynchronous-set, clock-clear event flag. It is instantiated twice, for clear and for preset.

Verification
REQ-033 reset, then enable=1, d=1 for 2 edges, q follows correctly -> check_count=1, error_count=0, mismatch never 1.
REQ-034 2-unit preset pulse between edges, q=1 at next edge -> no mismatch. Same pulse with q held 0 -> mismatch=1 for one cycle, error_count=1.
REQ-035 clear=preset=1 at an edge, q=0 -> no error; expected_q=0.
REQ-036 ERR_LIMIT=2, force q inverted for 3 compare edges -> error_count=2, halted=1, state=HALT, check_count frozen at 2.
REQ-037 enable dropped for 1 cycle in VALID -> state UNKNOWN; next edge reloads without compare; check_count unchanged for 2 edges.
REQ-038 reset pulsed while state=HALT -> all outputs return to reset values within the reset assertion.
